// File: rtl/ctrl_pipe.sv
// Control-bundle pipeline behind decode, with per-stage hold/flush and a multi-cycle busy FSM.
// Latency: a bundle reaches stage i i+1 cycles after decode when nothing holds or flushes it.
// Backpressure: holds ripple towards decode and a busy multi-cycle op holds stage 0; optional stall counter under CTRL_PIPE_PERF_EN.
module ctrl_pipe #(
    parameter int CW        = 16,
    parameter int STAGES    = 3,
    parameter int MC_CYCLES = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CW-1:0]        ctrl_d,
    input  logic                 valid_d,
    input  logic [STAGES-1:0]    stall,
    input  logic [STAGES-1:0]    flush,
    input  logic                 mc_start,
    output logic [STAGES*CW-1:0] ctrl_q,
    output logic [STAGES-1:0]    valid_q,
    output logic [STAGES-1:0]    hold_q,
    output logic                 stall_d,
    output logic                 mc_busy,
    output logic                 mc_done,
    output logic [31:0]          stall_cnt
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mcState_t;

    localparam logic [7:0] MC_CNT_INIT = 8'(MC_CYCLES - 1);

    mcState_t          mcState, mcStateNext;
    logic [7:0]        mcCnt, mcCntNext;
    logic [CW-1:0]     stageCtrl [STAGES];
    logic [STAGES-1:0] stageVld;

    assign mc_busy = (mcState == BUSY);
    assign mc_done = (mcState == DONE);
    assign stall_d = hold_q[0];

    // A downstream hold backs up every stage in front of it.
    always_comb begin
        hold_q = stall;
        for (int i = STAGES - 2; i >= 0; i--) begin
            hold_q[i] = stall[i] | hold_q[i+1];
        end
        if (mc_busy) begin
            hold_q[0] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stageCtrl[i] <= '0;
            end
            stageVld <= '0;
        end else begin
            if (flush[0]) begin
                stageCtrl[0] <= '0;
                stageVld[0]  <= 1'b0;
            end else if (!hold_q[0]) begin
                stageCtrl[0] <= ctrl_d;
                stageVld[0]  <= valid_d;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (flush[i]) begin
                    stageCtrl[i] <= '0;
                    stageVld[i]  <= 1'b0;
                end else if (!hold_q[i]) begin
                    // Upstream is frozen: take a bubble so its bundle is not copied twice.
                    if (hold_q[i-1]) begin
                        stageCtrl[i] <= '0;
                        stageVld[i]  <= 1'b0;
                    end else begin
                        stageCtrl[i] <= stageCtrl[i-1];
                        stageVld[i]  <= stageVld[i-1];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : gStageOut
        assign ctrl_q[g*CW +: CW] = stageCtrl[g];
    end
    assign valid_q = stageVld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcState <= IDLE;
            mcCnt   <= '0;
        end else begin
            mcState <= mcStateNext;
            mcCnt   <= mcCntNext;
        end
    end

    always_comb begin
        mcStateNext = mcState;
        mcCntNext   = mcCnt;
        case (mcState)
            IDLE: begin
                if (mc_start && valid_d && !flush[0] && !hold_q[0]) begin
                    mcStateNext = BUSY;
                    mcCntNext   = MC_CNT_INIT;
                end
            end
            BUSY: begin
                // A flush of stage 0 kills the op silently.
                if (flush[0]) begin
                    mcStateNext = IDLE;
                end else if (mcCnt == 8'd0) begin
                    mcStateNext = DONE;
                end else begin
                    mcCntNext = mcCnt - 8'd1;
                end
            end
            DONE:    mcStateNext = IDLE;
            default: mcStateNext = IDLE;
        endcase
    end

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] stallCnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCnt <= '0;
        end else if (hold_q[0] && (stallCnt != 32'hFFFF_FFFF)) begin
            stallCnt <= stallCnt + 32'd1;
        end
    end

    assign stall_cnt = stallCnt;
`else
    assign stall_cnt = '0;
`endif

endmodule
